// File: rtl/divider_rr_scheduler.sv
// Round-robin front end for one shared 12b/6b restoring divider.
// Screens divide-by-zero and quotient overflow locally, sequences the
// start/done handshake, and answers with a timeout error if the divider hangs.
module divider_rr_scheduler #(
  parameter int NREQ      = 4,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*12-1:0] req_dividend,
  input  logic [NREQ*6-1:0] req_divisor,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [5:0]        rsp_quotient,
  output logic [6:0]        rsp_rem,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic [11:0]       div_dividend,
  output logic [5:0]        div_divisor,
  output logic              div_start,
  input  logic [5:0]        div_quotient,
  input  logic [6:0]        div_rem,
  input  logic              div_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] E_OK = 2'b00, E_DZ = 2'b01, E_OVF = 2'b10, E_TO = 2'b11;

  typedef struct packed {
    logic [5:0] q;
    logic [6:0] r;
    logic [1:0] e;
  } rsp_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr, gnt, sel;
  logic [PW:0]   cand;
  logic          sel_vld, sel_dz, sel_ovf;
  logic [11:0]   sel_dvd;
  logic [5:0]    sel_dvs;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          done_q, done_rise, start_last, to_hit;
  rsp_t          res;

  // Round-robin pick: first requester at or above ptr, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!sel_vld && req[cand[PW-1:0]]) begin
        sel_vld = 1'b1;
        sel     = cand[PW-1:0];
      end
    end
  end

  // Operand mux for the selected client.
  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel == PW'(k)) begin
        sel_dvd = req_dividend[12*k +: 12];
        sel_dvs = req_divisor[6*k +: 6];
      end
    end
  end

  // Quotient fits in 6b only when the dividend's upper half is below the divisor.
  assign sel_dz     = (sel_dvs == 6'd0);
  assign sel_ovf    = (sel_dvd[11:6] >= sel_dvs);
  assign done_rise  = div_done & ~done_q;
  assign start_last = (scnt == SW'(START_CYC-1));
  assign to_hit     = (tcnt == TW'(TIMEOUT-1));
  assign busy       = (state != S_IDLE);
  assign div_start  = (state == S_START);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (sel_vld) state_nx = (sel_dz || sel_ovf) ? S_RESP : S_START;
      S_START: if (start_last) state_nx = S_WAIT;
      S_WAIT:  if (done_rise || to_hit) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Grant/latch, counters, result capture and response drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack          <= '0;
      rsp_valid    <= '0;
      rsp_quotient <= '0;
      rsp_rem      <= '0;
      rsp_err      <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      ptr          <= '0;
      gnt          <= '0;
      scnt         <= '0;
      tcnt         <= '0;
      done_q       <= 1'b0;
      res          <= '0;
    end else begin
      done_q    <= div_done;
      ack       <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: if (sel_vld) begin
          ack[sel]     <= 1'b1;
          gnt          <= sel;
          div_dividend <= sel_dvd;
          div_divisor  <= sel_dvs;
          scnt         <= '0;
          tcnt         <= '0;
          if (sel_dz)       res <= '{q: 6'h3F, r: 7'd0, e: E_DZ};
          else if (sel_ovf) res <= '{q: 6'h3F, r: 7'd0, e: E_OVF};
        end
        S_START: scnt <= scnt + 1'b1;
        S_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (done_rise)   res <= '{q: div_quotient, r: div_rem, e: E_OK};
          else if (to_hit) res <= '{q: 6'd0, r: 7'd0, e: E_TO};
        end
        S_RESP: begin
          rsp_valid[gnt] <= 1'b1;
          rsp_quotient   <= res.q;
          rsp_rem        <= res.r;
          rsp_err        <= res.e;
          ptr            <= (gnt == PW'(NREQ-1)) ? '0 : gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_rr_scheduler.sv
// Bench for divider_rr_scheduler: divider model, transaction-level reference
// model, per-cycle compare, directed scenarios then random traffic.
module tb_divider_rr_scheduler;
  localparam int NREQ = 4, S = 2, TO = 64;

  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*12-1:0] req_dividend = '0;
  logic [NREQ*6-1:0]  req_divisor = '0;
  logic [NREQ-1:0]    ack, rsp_valid;
  logic [5:0]         rsp_quotient;
  logic [6:0]         rsp_rem;
  logic [1:0]         rsp_err;
  logic               busy, div_start;
  logic [11:0]        div_dividend;
  logic [5:0]         div_divisor;
  logic [5:0]         div_quotient = '0;
  logic [6:0]         div_rem = '0;
  logic               div_done = 1'b0;

  divider_rr_scheduler #(.NREQ(NREQ), .START_CYC(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_rem(rsp_rem),
    .rsp_err(rsp_err), .busy(busy), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_start(div_start), .div_quotient(div_quotient), .div_rem(div_rem), .div_done(div_done));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider: result appears dlat cycles after start drops; hang keeps done low.
  int dlat = 3, dcnt = 0;
  bit hang = 0, dstarted = 0;
  logic [5:0] dq;
  logic [6:0] dr;
  initial forever begin
    @(negedge clk);
    if (div_start) begin
      div_done = 1'b0; dcnt = 0; dstarted = 1;
      dq = 6'(div_dividend / div_divisor);
      dr = 7'(div_dividend % div_divisor);
    end else if (dstarted && !div_done && !hang) begin
      dcnt++;
      if (dcnt >= dlat) begin div_done = 1'b1; div_quotient = dq; div_rem = dr; end
    end
  end

  // Reference model: one job at a time, timed in edge numbers.
  int  m_edge = 0, m_gedge = 0, m_rsp_edge = -1, m_ptr = 0, m_g = 0, m_dvd = 0, m_dvs = 0;
  bit  m_active = 0, m_byp = 0, m_prev = 0, cmp_en = 0;
  logic [NREQ-1:0] m_ack = '0, m_rspv = '0;
  logic [5:0] m_q = '0, m_rq = '0;
  logic [6:0] m_r = '0, m_rr = '0;
  logic [1:0] m_e = '0, m_re = '0;
  logic m_start = 0, m_busy = 0;

  always @(posedge clk) begin : model
    bit rise;
    int gi;
    m_edge++;
    m_ack = '0; m_rspv = '0;
    if (rst) begin
      m_active = 0; m_ptr = 0; m_q = '0; m_r = '0; m_e = '0; m_dvd = 0; m_dvs = 0;
      m_prev = 0; m_start = 0; m_busy = 0; cmp_en = 1;
    end else begin
      rise = div_done && !m_prev;
      m_prev = div_done;
      if (m_active) begin
        if (m_rsp_edge < 0 && m_edge >= m_gedge + S + 1 && rise) begin
          m_rq = 6'(m_dvd / m_dvs); m_rr = 7'(m_dvd % m_dvs); m_re = 2'd0; m_rsp_edge = m_edge + 1;
        end else if (m_rsp_edge < 0 && m_edge == m_gedge + S + TO) begin
          m_rq = 6'd0; m_rr = 7'd0; m_re = 2'd3; m_rsp_edge = m_edge + 1;
        end else if (m_edge == m_rsp_edge) begin
          m_rspv[m_g] = 1'b1; m_q = m_rq; m_r = m_rr; m_e = m_re;
          m_ptr = (m_g + 1) % NREQ; m_active = 0;
        end
      end else if (req != '0) begin
        gi = -1;
        for (int k = 0; k < NREQ; k++)
          if (gi < 0 && req[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
        m_g = gi; m_ack[gi] = 1'b1; m_active = 1; m_gedge = m_edge;
        m_dvd = int'(req_dividend[12*gi +: 12]);
        m_dvs = int'(req_divisor[6*gi +: 6]);
        m_byp = 1; m_rsp_edge = m_edge + 1; m_rq = 6'h3F; m_rr = 7'd0;
        if (m_dvs == 0) m_re = 2'd1;
        else if (m_dvd / m_dvs > 63) m_re = 2'd2;
        else begin m_byp = 0; m_rsp_edge = -1; end
      end
      m_start = m_active && !m_byp && (m_edge < m_gedge + S);
      m_busy  = m_active;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) if (cmp_en) begin
    chk("ack", 32'(ack), 32'(m_ack));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rspv));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("div_start", 32'(div_start), 32'(m_start));
    chk("div_dividend", 32'(div_dividend), 32'(m_dvd));
    chk("div_divisor", 32'(div_divisor), 32'(m_dvs));
    chk("rsp_quotient", 32'(rsp_quotient), 32'(m_q));
    chk("rsp_rem", 32'(rsp_rem), 32'(m_r));
    chk("rsp_err", 32'(rsp_err), 32'(m_e));
  end

  bit keep_req = 0, saw_start = 0;
  int gq[$];

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) if (ack[k]) gq.push_back(k);
    if (!keep_req) req = req & ~ack;
    if (div_start) saw_start = 1;
  endtask

  task automatic set_op(int i, int dvd, int dvs);
    req_dividend[12*i +: 12] = 12'(dvd);
    req_divisor[6*i +: 6]    = 6'(dvs);
  endtask

  task automatic wait_ack(output int g);
    g = -1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (|ack) begin
        for (int k = 0; k < NREQ; k++) if (ack[k]) g = k;
        return;
      end
    end
    chk("wait_ack", 32'(ack), 32'(1));
  endtask

  task automatic wait_rsp(int i, output logic [5:0] q, output logic [6:0] r,
                          output logic [1:0] e, output int lat);
    q = '0; r = '0; e = '0;
    for (lat = 1; lat <= 300; lat++) begin
      tick();
      if (rsp_valid[i]) begin q = rsp_quotient; r = rsp_rem; e = rsp_err; return; end
    end
    chk("wait_rsp", 32'(rsp_valid), 32'(1) << i);
  endtask

  initial begin
    int g, lat;
    logic [5:0] q;
    logic [6:0] r;
    logic [1:0] e;
    int dvs, dvd;

    repeat (3) tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div_start", 32'(div_start), 0);
    rst = 1'b0;

    // Single client, divider path.
    set_op(0, 693, 11); req = 4'b0001;
    wait_ack(g); chk("t1_grant", g, 0);
    wait_rsp(0, q, r, e, lat);
    chk("t1_q", 32'(q), 63); chk("t1_rem", 32'(r), 0); chk("t1_err", 32'(e), 0);

    // Divide by zero bypass.
    set_op(2, 24, 0); req = 4'b0100; saw_start = 0;
    wait_ack(g); chk("t3_grant", g, 2);
    wait_rsp(2, q, r, e, lat);
    chk("t3_lat", lat, 1); chk("t3_q", 32'(q), 63); chk("t3_rem", 32'(r), 0);
    chk("t3_err", 32'(e), 1); chk("t3_no_start", 32'(saw_start), 0);

    // Overflow bypass, then an in-range divide.
    set_op(1, 12'h800, 16); req = 4'b0010; saw_start = 0;
    wait_ack(g); wait_rsp(1, q, r, e, lat);
    chk("t4_lat", lat, 1); chk("t4_q", 32'(q), 63); chk("t4_err", 32'(e), 2);
    chk("t4_no_start", 32'(saw_start), 0);
    set_op(1, 512, 16); req = 4'b0010;
    wait_ack(g); wait_rsp(1, q, r, e, lat);
    chk("t4b_q", 32'(q), 32); chk("t4b_rem", 32'(r), 0); chk("t4b_err", 32'(e), 0);

    // Hung divider -> timeout, then normal service.
    hang = 1; set_op(3, 100, 5); req = 4'b1000;
    wait_ack(g); wait_rsp(3, q, r, e, lat);
    chk("t5_lat", lat, S + TO + 1); chk("t5_err", 32'(e), 3); chk("t5_q", 32'(q), 0);
    hang = 0; set_op(0, 100, 7); req = 4'b0001;
    wait_ack(g); wait_rsp(0, q, r, e, lat);
    chk("t5b_q", 32'(q), 14); chk("t5b_rem", 32'(r), 2); chk("t5b_err", 32'(e), 0);

    // Round-robin fairness from a fresh pointer.
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < NREQ; i++) set_op(i, 100 + 37 * i, 7 + i);
    keep_req = 1; req = 4'b1111; gq.delete();
    for (int n = 0; n < 2000 && gq.size() < 6; n++) tick();
    req = 4'b1010;
    for (int n = 0; n < 2000 && gq.size() < 7; n++) tick();
    req = '0; keep_req = 0;
    chk("t2_count", gq.size(), 7);
    if (gq.size() == 7) begin
      chk("t2_g0", gq[0], 0); chk("t2_g1", gq[1], 1); chk("t2_g2", gq[2], 2);
      chk("t2_g3", gq[3], 3); chk("t2_g4", gq[4], 0); chk("t2_g5", gq[5], 1);
      chk("t2_g6", gq[6], 3);
    end
    repeat (100) tick();

    // Reset while waiting on the divider.
    dlat = 30; set_op(1, 300, 9); req = 4'b0010;
    wait_ack(g);
    repeat (S + 2) tick();
    chk("t6_busy_pre", 32'(busy), 1); chk("t6_wait", 32'(div_start), 0);
    rst = 1; tick();
    chk("t6_ack", 32'(ack), 0); chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_busy", 32'(busy), 0); chk("t6_dvd", 32'(div_dividend), 0);
    chk("t6_err", 32'(rsp_err), 0);
    rst = 0; set_op(3, 50, 5); req = 4'b1010;
    wait_ack(g); chk("t6_regrant", g, 1);
    wait_rsp(1, q, r, e, lat);
    chk("t6_q", 32'(q), 33); chk("t6_rem", 32'(r), 3); chk("t6_rsp_err", 32'(e), 0);
    dlat = 3;
    repeat (100) tick();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          dvs = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
          if (dvs != 0 && $urandom_range(0, 2) != 0) dvd = int'($urandom_range(0, dvs * 64 - 1));
          else dvd = int'($urandom_range(0, 4095));
          set_op(i, dvd, dvs);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (div_start) begin
        dlat = int'($urandom_range(1, 12));
        hang = ($urandom_range(0, 11) == 0);
      end
      tick();
    end
    rst = 0; req = '0; hang = 0;
    repeat (150) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
